// File: rtl/buf_arb_pkg.sv
// rtl/buf_arb_pkg.sv - shared types and default constants for the frame-buffer write arbiter
package buf_arb_pkg;

    localparam int          IMA_SIZE_DEF    = 19200;
    localparam logic [11:0] CLEAR_COLOR_DEF = 12'h000;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_CAM,
        GNT_CPU
    } grant_t;

endpackage

// File: rtl/buf_arb_grant.sv
// rtl/buf_arb_grant.sv - camera/cpu grant selection; BUF_ARB_RR_EN selects round-robin over fixed priority
module buf_arb_grant
    import buf_arb_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   arb_en,
    input  logic   cam_valid,
    input  logic   cpu_req,
    output grant_t grant
);

`ifdef BUF_ARB_RR_EN
    logic rr_cpu_q, rr_cpu_d;

    // Pointer only decides ties; a lone requester is always served.
    always_comb begin
        grant    = GNT_NONE;
        rr_cpu_d = rr_cpu_q;
        if (arb_en) begin
            if (cam_valid && (!cpu_req || !rr_cpu_q)) begin
                grant = GNT_CAM;
            end else if (cpu_req) begin
                grant = GNT_CPU;
            end
        end
        if (grant == GNT_CAM) begin
            rr_cpu_d = 1'b1;
        end else if (grant == GNT_CPU) begin
            rr_cpu_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_cpu_q <= 1'b0;
        end else begin
            rr_cpu_q <= rr_cpu_d;
        end
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset;

    always_comb begin
        grant = GNT_NONE;
        if (arb_en) begin
            if (cam_valid) begin
                grant = GNT_CAM;
            end else if (cpu_req) begin
                grant = GNT_CPU;
            end
        end
    end
`endif

endmodule

// File: rtl/buffer_write_arbiter.sv
// rtl/buffer_write_arbiter.sv - frame-buffer write port owner: camera/cpu arbitration, clear engine, black-pixel guard (BUF_ARB_RR_EN in buf_arb_grant)
module buffer_write_arbiter
    import buf_arb_pkg::*;
#(
    parameter int             AW          = 15,
    parameter int             DW          = 12,
    parameter int             IMA_SIZE    = IMA_SIZE_DEF,
    parameter logic [DW-1:0]  CLEAR_COLOR = DW'(CLEAR_COLOR_DEF)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cam_valid,
    input  logic [AW-1:0] cam_addr,
    input  logic [DW-1:0] cam_data,
    output logic          cam_ready,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_data,
    output logic          cpu_ack,
    input  logic          clear_start,
    output logic          clear_busy,
    output logic          clear_done,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          wr_en
);

    localparam logic [AW-1:0] LIMIT     = AW'(IMA_SIZE);
    localparam logic [AW-1:0] LAST_ADDR = AW'(IMA_SIZE - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic          done_q, done_d;
    logic          arb_en;
    grant_t        grant;

    // A clear request pre-empts arbitration in the very cycle it arrives.
    assign arb_en = (state_q == ST_IDLE) && !clear_start;

    buf_arb_grant u_grant (
        .clk       (clk),
        .reset     (reset),
        .arb_en    (arb_en),
        .cam_valid (cam_valid),
        .cpu_req   (cpu_req),
        .grant     (grant)
    );

    assign cam_ready  = (grant == GNT_CAM);
    assign cpu_ack    = (grant == GNT_CPU);
    assign clear_busy = (state_q == ST_CLEAR) || clear_start;
    assign clear_done = done_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clear_start) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end else if (grant == GNT_CAM) begin
                    wr_addr_d = cam_addr;
                    wr_data_d = cam_data;
                    wr_en_d   = (cam_addr < LIMIT);
                end else if (grant == GNT_CPU) begin
                    wr_addr_d = cpu_addr;
                    wr_data_d = cpu_data;
                    wr_en_d   = (cpu_addr < LIMIT);
                end
            end
            ST_CLEAR: begin
                wr_en_d   = 1'b1;
                wr_addr_d = cnt_q;
                wr_data_d = CLEAR_COLOR;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_buffer_write_arbiter.sv
// tb/tb_buffer_write_arbiter.sv - self-checking bench for buffer_write_arbiter
module tb_buffer_write_arbiter;

    localparam int IMA = 19200;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cam_valid = 1'b0;
    logic [14:0] cam_addr = '0;
    logic [11:0] cam_data = '0;
    logic        cam_ready;
    logic        cpu_req = 1'b0;
    logic [14:0] cpu_addr = '0;
    logic [11:0] cpu_data = '0;
    logic        cpu_ack;
    logic        clear_start = 1'b0;
    logic        clear_busy;
    logic        clear_done;
    logic [14:0] wr_addr;
    logic [11:0] wr_data;
    logic        wr_en;

    int n_checks = 0;
    int n_errors = 0;
    bit m_turn_cpu = 1'b0;

    typedef struct {
        logic        cv;
        logic [14:0] ca;
        logic [11:0] cd;
        logic        cr;
        logic [14:0] pa;
        logic [11:0] pd;
        logic        e_rdy;
        logic        e_ack;
        logic        e_wen;
        logic [14:0] e_addr;
        logic [11:0] e_data;
    } vec_t;

    vec_t tbl [9];

    buffer_write_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .cam_valid   (cam_valid),
        .cam_addr    (cam_addr),
        .cam_data    (cam_data),
        .cam_ready   (cam_ready),
        .cpu_req     (cpu_req),
        .cpu_addr    (cpu_addr),
        .cpu_data    (cpu_data),
        .cpu_ack     (cpu_ack),
        .clear_start (clear_start),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_en       (wr_en)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Reference: 0 = no grant, 1 = camera, 2 = cpu.
    function automatic int model_grant(input logic cv, input logic cr);
        int g = 0;
`ifdef BUF_ARB_RR_EN
        if (cv && cr) g = m_turn_cpu ? 2 : 1;
        else if (cv)  g = 1;
        else if (cr)  g = 2;
        if (g != 0) m_turn_cpu = (g == 1);
`else
        if (cv)      g = 1;
        else if (cr) g = 2;
`endif
        return g;
    endfunction

    function automatic vec_t model_vec(input logic cv, input logic [14:0] ca, input logic [11:0] cd,
                                       input logic cr, input logic [14:0] pa, input logic [11:0] pd);
        vec_t v;
        int g;
        g = model_grant(cv, cr);
        v.cv = cv; v.ca = ca; v.cd = cd; v.cr = cr; v.pa = pa; v.pd = pd;
        v.e_rdy  = (g == 1);
        v.e_ack  = (g == 2);
        v.e_addr = (g == 2) ? pa : ca;
        v.e_data = (g == 2) ? pd : cd;
        v.e_wen  = (g != 0) && (int'(v.e_addr) < IMA);
        return v;
    endfunction

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        cam_valid = v.cv; cam_addr = v.ca; cam_data = v.cd;
        cpu_req = v.cr; cpu_addr = v.pa; cpu_data = v.pd;
        clear_start = 1'b0;
        #1;
        chk({tag, "_cam_ready"}, int'(cam_ready), int'(v.e_rdy));
        chk({tag, "_cpu_ack"}, int'(cpu_ack), int'(v.e_ack));
        @(posedge clk);
        #1;
        chk({tag, "_wr_en"}, int'(wr_en), int'(v.e_wen));
        if (v.e_wen) begin
            chk({tag, "_wr_addr"}, int'(wr_addr), int'(v.e_addr));
            chk({tag, "_wr_data"}, int'(wr_data), int'(v.e_data));
        end
    endtask

    task automatic idle_inputs();
        cam_valid = 1'b0; cpu_req = 1'b0; clear_start = 1'b0;
    endtask

    // Full clear with optional held requesters and an optional duplicate start mid-clear.
    task automatic do_clear(input logic reqs, input int dup_at, input string tag);
        int  writes = 0, dones = 0, bad_seq = 0, bad_grant = 0, bad_busy = 0, cyc = 0;
        int  busy_at_done = -1, addr_at_done = -1;
        bit  fin = 1'b0;
        @(negedge clk);
        cam_valid = reqs; cam_addr = 15'd7; cam_data = 12'h5A5;
        cpu_req = reqs; cpu_addr = 15'd9; cpu_data = 12'h3C3;
        clear_start = 1'b1;
        #1;
        chk({tag, "_start_busy"}, int'(clear_busy), 1);
        chk({tag, "_start_cam_ready"}, int'(cam_ready), 0);
        chk({tag, "_start_cpu_ack"}, int'(cpu_ack), 0);
        while (!fin && cyc < IMA + 50) begin
            @(negedge clk);
            clear_start = (dup_at >= 0 && writes == dup_at);
            #1;
            cyc++;
            if (wr_en) begin
                if (int'(wr_addr) != writes || wr_data != 12'h000) bad_seq++;
                writes++;
            end
            if (clear_done) begin
                dones++;
                fin = 1'b1;
                busy_at_done = int'(clear_busy);
                addr_at_done = int'(wr_addr);
            end else begin
                if (!clear_busy) bad_busy++;
                if (cam_ready || cpu_ack) bad_grant++;
            end
        end
        chk({tag, "_finished"}, int'(fin), 1);
        chk({tag, "_writes"}, writes, IMA);
        chk({tag, "_seq"}, bad_seq, 0);
        chk({tag, "_no_grant"}, bad_grant, 0);
        chk({tag, "_busy_held"}, bad_busy, 0);
        chk({tag, "_busy_at_done"}, busy_at_done, 0);
        chk({tag, "_last_addr"}, addr_at_done, IMA - 1);
        if (fin && reqs) begin
            int g;
            g = model_grant(1'b1, 1'b1);
            chk({tag, "_resume_cam_ready"}, int'(cam_ready), int'(g == 1));
            chk({tag, "_resume_cpu_ack"}, int'(cpu_ack), int'(g == 2));
        end
        @(negedge clk);
        clear_start = 1'b0;
        #1;
        chk({tag, "_done_once"}, dones + int'(clear_done), 1);
        idle_inputs();
    endtask

    initial begin
        vec_t v;
        bit   pend;
        logic [14:0] pa;
        logic [11:0] pd;

        tbl[0] = '{1'b1, 15'd5,     12'hABC, 1'b0, 15'd0,     12'h000, 1'b1, 1'b0, 1'b1, 15'd5,     12'hABC};
        tbl[1] = '{1'b0, 15'd0,     12'h000, 1'b1, 15'd100,   12'h123, 1'b0, 1'b1, 1'b1, 15'd100,   12'h123};
        tbl[2] = '{1'b0, 15'd0,     12'h000, 1'b0, 15'd0,     12'h000, 1'b0, 1'b0, 1'b0, 15'd0,     12'h000};
        tbl[3] = '{1'b0, 15'd0,     12'h000, 1'b1, 15'd19200, 12'hFFF, 1'b0, 1'b1, 1'b0, 15'd0,     12'h000};
        tbl[4] = '{1'b1, 15'd19200, 12'h111, 1'b0, 15'd0,     12'h000, 1'b1, 1'b0, 1'b0, 15'd0,     12'h000};
        tbl[5] = '{1'b1, 15'd32767, 12'h222, 1'b0, 15'd0,     12'h000, 1'b1, 1'b0, 1'b0, 15'd0,     12'h000};
        tbl[6] = '{1'b1, 15'd19199, 12'h333, 1'b0, 15'd0,     12'h000, 1'b1, 1'b0, 1'b1, 15'd19199, 12'h333};
        tbl[7] = '{1'b0, 15'd0,     12'h000, 1'b1, 15'd0,     12'h456, 1'b0, 1'b1, 1'b1, 15'd0,     12'h456};
        tbl[8] = '{1'b0, 15'd0,     12'h000, 1'b0, 15'd0,     12'h000, 1'b0, 1'b0, 1'b0, 15'd0,     12'h000};

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cam_ready", int'(cam_ready), 0);
        chk("rst_cpu_ack", int'(cpu_ack), 0);
        chk("rst_clear_busy", int'(clear_busy), 0);
        chk("rst_clear_done", int'(clear_done), 0);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        reset = 1'b0;
        m_turn_cpu = 1'b0;

        for (int i = 0; i < 9; i++) begin
            void'(model_grant(tbl[i].cv, tbl[i].cr));
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Both requesters held
        for (int i = 0; i < 6; i++) begin
            v = model_vec(1'b1, 15'd20 + 15'(i), 12'h0A0 + 12'(i), 1'b1, 15'd40 + 15'(i), 12'h0B0 + 12'(i));
            apply(v, $sformatf("contend%0d", i));
        end

        // Random traffic; cpu keeps its request stable until acked
        pend = 1'b0; pa = '0; pd = '0;
        for (int i = 0; i < 300; i++) begin
            if (!pend && ($urandom % 2 == 1)) begin
                pend = 1'b1;
                pa = 15'($urandom_range(0, IMA + 100));
                pd = 12'($urandom);
            end
            v = model_vec(1'($urandom % 3 != 0), 15'($urandom_range(0, IMA + 100)), 12'($urandom),
                          pend, pa, pd);
            apply(v, $sformatf("rand%0d", i));
            if (v.e_ack) pend = 1'b0;
        end
        @(negedge clk);
        idle_inputs();

        // Clear with both requesters waiting and a duplicate start mid-clear
        do_clear(1'b1, 5000, "clr1");

        // Reset in the middle of a clear
        begin
            int  cyc = 0;
            int  stray = 0;
            bit  hit = 1'b0;
            @(negedge clk);
            clear_start = 1'b1;
            while (!hit && cyc < 300) begin
                @(negedge clk);
                clear_start = 1'b0;
                #1;
                cyc++;
                if (wr_en && wr_addr == 15'd100) hit = 1'b1;
            end
            chk("abort_reached_100", int'(hit), 1);
            reset = 1'b1;
            @(negedge clk);
            #1;
            chk("abort_cam_ready", int'(cam_ready), 0);
            chk("abort_cpu_ack", int'(cpu_ack), 0);
            chk("abort_busy", int'(clear_busy), 0);
            chk("abort_done", int'(clear_done), 0);
            chk("abort_wr_en", int'(wr_en), 0);
            chk("abort_wr_addr", int'(wr_addr), 0);
            chk("abort_wr_data", int'(wr_data), 0);
            reset = 1'b0;
            m_turn_cpu = 1'b0;
            repeat (4) begin
                @(negedge clk);
                #1;
                if (clear_done || clear_busy || wr_en) stray++;
            end
            chk("abort_no_resume", stray, 0);
        end

        do_clear(1'b0, -1, "clr2");

        // Arbitration still works after the clears
        v = model_vec(1'b0, 15'd0, 12'h000, 1'b1, 15'd321, 12'h789);
        apply(v, "post_cpu");
        v = model_vec(1'b1, 15'd19200, 12'hFFF, 1'b0, 15'd0, 12'h000);
        apply(v, "post_black");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
